// File: rtl/risc16_mem_pkg.sv
// Shared definitions for the risc16 memory responder: I/O page offsets,
// loader state encoding and the big-endian byte-lane merge.
package risc16_mem_pkg;

    localparam logic [7:0] IO_LED    = 8'h00;
    localparam logic [7:0] IO_CYCLE  = 8'h02;
    localparam logic [7:0] IO_STATUS = 8'h04;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        DONE = 2'd3
    } ld_state_t;

    // Lane 0 is the even (high) byte, lane 1 the odd (low) byte.
    function automatic logic [15:0] lane_merge(input logic [15:0] old_word,
                                               input logic [15:0] new_word,
                                               input logic [1:0]  we);
        logic [15:0] merged;
        merged[15:8] = we[0] ? new_word[15:8] : old_word[15:8];
        merged[7:0]  = we[1] ? new_word[7:0]  : old_word[7:0];
        return merged;
    endfunction

endpackage

// File: rtl/risc16_mem_loader.sv
// Byte-stream program loader: packs big-endian byte pairs into words,
// holds the core in reset while loading, and issues word write requests.
module risc16_mem_loader
    import risc16_mem_pkg::*;
#(
    parameter int WORDS_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_ld_start,
    input  logic                  i_ld_valid,
    input  logic [7:0]            i_ld_data,
    input  logic                  i_ld_last,
    output logic                  o_ld_ready,
    output logic                  o_cpu_rst,
    output logic                  o_busy,
    output logic                  o_wr_en,
    output logic [WORDS_LOG2-1:0] o_wr_addr,
    output logic [15:0]           o_wr_data
);

    ld_state_t             r_state;
    ld_state_t             w_next;
    logic [WORDS_LOG2-1:0] r_wp;
    logic [7:0]            r_hi;
    logic                  r_cpu_rst;
    logic                  w_wr_en;
    logic [15:0]           w_wr_data;

    // Next-state and write-request decode.
    always_comb begin
        w_next    = r_state;
        w_wr_en   = 1'b0;
        w_wr_data = 16'h0000;
        case (r_state)
            IDLE: begin
                if (i_ld_start) w_next = HI;
                else            w_next = IDLE;
            end
            HI: begin
                if (i_ld_valid) begin
                    if (i_ld_last) begin
                        w_next    = DONE;
                        w_wr_en   = 1'b1;
                        w_wr_data = {i_ld_data, 8'h00};
                    end else begin
                        w_next    = LO;
                    end
                end else begin
                    w_next = HI;
                end
            end
            LO: begin
                if (i_ld_valid) begin
                    w_wr_en   = 1'b1;
                    w_wr_data = {r_hi, i_ld_data};
                    w_next    = i_ld_last ? DONE : HI;
                end else begin
                    w_next = LO;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State, word pointer, high-byte latch and core reset register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_wp      <= '0;
            r_hi      <= 8'h00;
            r_cpu_rst <= 1'b1;
        end else begin
            r_state   <= w_next;
            r_cpu_rst <= (w_next != IDLE);
            if (r_state == IDLE && i_ld_start) begin
                r_wp <= '0;
            end else if (r_state == LO && i_ld_valid) begin
                r_wp <= r_wp + WORDS_LOG2'(1);
            end
            if (r_state == HI && i_ld_valid) begin
                r_hi <= i_ld_data;
            end
        end
    end

    assign o_ld_ready = (r_state == HI) || (r_state == LO);
    assign o_busy     = (r_state != IDLE);
    assign o_cpu_rst  = r_cpu_rst;
    assign o_wr_en    = w_wr_en;
    assign o_wr_addr  = r_wp;
    assign o_wr_data  = w_wr_data;

endmodule

// File: rtl/risc16_mem_resp.sv
// Zero-wait-state memory responder for risc16b: unified RAM shared by the
// fetch and data ports, a small I/O page, and the program loader.
module risc16_mem_resp
    import risc16_mem_pkg::*;
#(
    parameter int          WORDS_LOG2 = 12,
    parameter logic [15:0] IO_BASE    = 16'hFF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_addr,
    input  logic        i_oe,
    output logic [15:0] i_din,
    input  logic [15:0] d_addr,
    input  logic        d_oe,
    input  logic [15:0] d_dout,
    input  logic [1:0]  d_we,
    output logic [15:0] d_din,
    output logic        cpu_rst,
    input  logic        ld_start,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic [15:0] led
);

    logic [15:0]           r_ram [0:(1<<WORDS_LOG2)-1];
    logic [15:0]           r_led;
    logic [15:0]           r_cycle;
    logic [WORDS_LOG2-1:0] w_i_idx;
    logic [WORDS_LOG2-1:0] w_d_idx;
    logic [7:0]            w_io_off;
    logic                  w_io;
    logic [1:0]            w_core_we;
    logic [1:0]            w_led_we;
    logic                  w_cpu_rst;
    logic                  w_busy;
    logic                  w_ld_wr;
    logic [WORDS_LOG2-1:0] w_ld_addr;
    logic [15:0]           w_ld_data;
    logic [15:0]           w_d_din;
    logic                  w_unused;

    risc16_mem_loader #(.WORDS_LOG2(WORDS_LOG2)) u_loader (
        .clk        (clk),
        .rst        (rst),
        .i_ld_start (ld_start),
        .i_ld_valid (ld_valid),
        .i_ld_data  (ld_data),
        .i_ld_last  (ld_last),
        .o_ld_ready (ld_ready),
        .o_cpu_rst  (w_cpu_rst),
        .o_busy     (w_busy),
        .o_wr_en    (w_ld_wr),
        .o_wr_addr  (w_ld_addr),
        .o_wr_data  (w_ld_data)
    );

    assign w_i_idx   = i_addr[WORDS_LOG2:1];
    assign w_d_idx   = d_addr[WORDS_LOG2:1];
    assign w_io      = (d_addr[15:8] == IO_BASE[15:8]);
    assign w_io_off  = {d_addr[7:1], 1'b0};
    // While the core is held in reset the loader owns the write port.
    assign w_core_we = (!w_cpu_rst && !w_io) ? d_we : 2'b00;
    assign w_led_we  = (!w_cpu_rst && w_io && w_io_off == IO_LED) ? d_we : 2'b00;
    assign w_unused  = ^{i_addr[15:WORDS_LOG2+1], i_addr[0], d_addr[0]};

    // RAM write port; contents deliberately survive rst.
    always_ff @(posedge clk) begin
        if (w_ld_wr) begin
            r_ram[w_ld_addr] <= w_ld_data;
        end else if (w_core_we != 2'b00) begin
            r_ram[w_d_idx] <= lane_merge(r_ram[w_d_idx], d_dout, w_core_we);
        end
    end

    // LED register and free-running cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_led   <= 16'h0000;
            r_cycle <= 16'h0000;
        end else begin
            r_led <= lane_merge(r_led, d_dout, w_led_we);
            if (ld_start) r_cycle <= 16'h0000;
            else          r_cycle <= r_cycle + 16'h0001;
        end
    end

    // Data-port read mux over RAM and the I/O page.
    always_comb begin
        w_d_din = 16'h0000;
        if (!d_oe) begin
            w_d_din = 16'h0000;
        end else if (w_io) begin
            case (w_io_off)
                IO_LED:    w_d_din = r_led;
                IO_CYCLE:  w_d_din = r_cycle;
                IO_STATUS: w_d_din = {15'b0, w_busy};
                default:   w_d_din = 16'h0000;
            endcase
        end else begin
            w_d_din = r_ram[w_d_idx];
        end
    end

    assign i_din   = i_oe ? r_ram[w_i_idx] : 16'h0000;
    assign d_din   = w_d_din;
    assign cpu_rst = w_cpu_rst;
    assign led     = r_led;

endmodule

// File: tb/tb_risc16_mem_resp.sv
// Directed bench for risc16_mem_resp; expectations are queued by the
// stimulus and compared by a negedge monitor.
module tb_risc16_mem_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] i_addr = 16'h0;
    logic        i_oe = 1'b0;
    logic [15:0] i_din;
    logic [15:0] d_addr = 16'h0;
    logic        d_oe = 1'b0;
    logic [15:0] d_dout = 16'h0;
    logic [1:0]  d_we = 2'b00;
    logic [15:0] d_din;
    logic        cpu_rst;
    logic        ld_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data = 8'h0;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic [15:0] led;

    localparam int K_IDIN = 0, K_DDIN = 1, K_LED = 2, K_CPURST = 3, K_LDRDY = 4;

    typedef struct {
        int          kind;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    risc16_mem_resp dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_oe(i_oe), .i_din(i_din),
        .d_addr(d_addr), .d_oe(d_oe), .d_dout(d_dout), .d_we(d_we), .d_din(d_din),
        .cpu_rst(cpu_rst),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(ld_ready), .led(led)
    );

    always #5 clk = ~clk;

    // Monitor: every expectation queued this cycle is checked mid-cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] act;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_IDIN:   act = i_din;
                K_DDIN:   act = d_din;
                K_LED:    act = led;
                K_CPURST: act = {15'b0, cpu_rst};
                K_LDRDY:  act = {15'b0, ld_ready};
                default:  act = 16'hxxxx;
            endcase
            vectors++;
            if (act !== e.exp) begin
                miscompares++;
                $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int kind, input logic [15:0] exp, input string name);
        exp_t e;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        ld_valid = 1'b1;
        ld_data  = b;
        ld_last  = last;
        chk(K_LDRDY, 16'h0001, "ld_ready_hi_lo");
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic core_write(input logic [15:0] a, input logic [15:0] v, input logic [1:0] we);
        d_addr = a;
        d_dout = v;
        d_we   = we;
        tick();
        d_we   = 2'b00;
    endtask

    task automatic iread(input logic [15:0] a, input logic [15:0] exp, input string name);
        i_oe   = 1'b1;
        i_addr = a;
        chk(K_IDIN, exp, name);
        tick();
        i_oe   = 1'b0;
    endtask

    task automatic dread(input logic [15:0] a, input logic [15:0] exp, input string name);
        d_oe   = 1'b1;
        d_addr = a;
        chk(K_DDIN, exp, name);
        tick();
        d_oe   = 1'b0;
    endtask

    task automatic start_load();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    initial begin
        bit found;

        // 1: reset state, then a four-byte load
        tick();
        chk(K_CPURST, 16'h0001, "rst_cpu_rst");
        chk(K_LDRDY,  16'h0000, "rst_ld_ready");
        chk(K_LED,    16'h0000, "rst_led");
        dread(16'hFF04, 16'h0000, "rst_status");
        rst = 1'b0;
        tick();
        chk(K_CPURST, 16'h0000, "post_rst_cpu_rst");
        tick();
        start_load();
        chk(K_CPURST, 16'h0001, "load_cpu_rst");
        dread(16'hFF04, 16'h0001, "load_status_busy");
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h56, 1'b0);
        send_byte(8'h78, 1'b1);
        chk(K_CPURST, 16'h0001, "done_cpu_rst");
        chk(K_LDRDY,  16'h0000, "done_ld_ready");
        tick();
        chk(K_CPURST, 16'h0000, "idle_cpu_rst");
        iread(16'h0000, 16'h1234, "ld4_word0");
        iread(16'h0002, 16'h5678, "ld4_word1");
        chk(K_IDIN, 16'h0000, "i_oe_low");
        tick();

        // 2: byte in IDLE is dropped, then odd-length load
        chk(K_LDRDY, 16'h0000, "idle_ld_ready");
        ld_valid = 1'b1; ld_data = 8'hEE; ld_last = 1'b1;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        iread(16'h0000, 16'h1234, "idle_byte_dropped");
        start_load();
        send_byte(8'hAB, 1'b1);
        tick();
        iread(16'h0000, 16'hAB00, "odd_load_word0");
        iread(16'h0002, 16'h5678, "odd_load_word1_kept");

        // 3: byte lanes and read-before-write
        core_write(16'h1F00, 16'h1111, 2'b11);
        core_write(16'h0020, 16'hFFFF, 2'b11);
        d_oe = 1'b1;
        chk(K_DDIN, 16'hFFFF, "same_cycle_old_we01");
        core_write(16'h0020, 16'h5A00, 2'b01);
        chk(K_DDIN, 16'h5AFF, "lane_we01");
        core_write(16'h0020, 16'h00C3, 2'b10);
        d_oe = 1'b0;
        dread(16'h0020, 16'h5AC3, "lane_we10");

        // 4: I/O page
        core_write(16'hFF00, 16'hBEEF, 2'b11);
        chk(K_LED, 16'hBEEF, "led_write");
        dread(16'hFF00, 16'hBEEF, "led_read");
        core_write(16'hFF00, 16'h0012, 2'b10);
        chk(K_LED, 16'hBE12, "led_lane");
        core_write(16'hFF06, 16'h7777, 2'b11);
        dread(16'hFF06, 16'h0000, "io_unmapped");
        iread(16'h1F00, 16'h1111, "io_alias_untouched");

        // 5: reset during LO after three bytes
        start_load();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        rst = 1'b1;
        tick();
        chk(K_CPURST, 16'h0001, "midload_rst_cpu_rst");
        chk(K_LDRDY,  16'h0000, "midload_rst_idle");
        tick();
        rst = 1'b0;
        tick();
        chk(K_CPURST, 16'h0000, "midload_release");
        iread(16'h0000, 16'h1122, "midload_word0_kept");
        iread(16'h0002, 16'h5678, "midload_word1_kept");

        // 6: core stores ignored while held in reset; ld_start clears CYCLE
        start_load();
        dread(16'hFF02, 16'h0000, "cycle_cleared");
        core_write(16'h0000, 16'hDEAD, 2'b11);
        core_write(16'hFF00, 16'h0000, 2'b11);
        iread(16'h0000, 16'h1122, "store_in_reset_ignored");
        chk(K_LED, 16'h0000, "led_after_rst");
        send_byte(8'h99, 1'b1);
        tick();
        iread(16'h0000, 16'h9900, "reload_word0");

        // Cycle counter wrap
        d_addr = 16'hFF02;
        d_oe   = 1'b1;
        found  = 1'b0;
        for (int n = 0; n < 70000 && !found; n++) begin
            @(negedge clk);
            if (d_din == 16'hFFFF) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("FAIL cycle_reach_ffff: got timeout, expected 16'hffff");
        end else begin
            @(posedge clk);
            #1;
            chk(K_DDIN, 16'h0000, "cycle_wrap");
            tick();
            chk(K_DDIN, 16'h0001, "cycle_incr");
            tick();
        end
        d_oe = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
